// File: rtl/raxm_pkg.sv
// Shared address map, state encoding and bus payload for the RAxM initiator/responder pair.
package raxm_pkg;

  localparam int unsigned RAXM_OP_W  = 16;
  localparam int unsigned RAXM_ADR_W = 32;
  localparam int unsigned RAXM_DAT_W = 32;
  localparam int unsigned RAXM_SEL_W = 4;
  localparam int unsigned RAXM_TMO_W = 8;

  localparam logic [RAXM_ADR_W-1:0] RAXM_OFS_OPA = 32'h0000_0000;
  localparam logic [RAXM_ADR_W-1:0] RAXM_OFS_OPB = 32'h0000_0004;
  localparam logic [RAXM_ADR_W-1:0] RAXM_OFS_RES = 32'h0000_0008;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_RD_RES,
    ST_RESP
  } raxm_init_state_t;

  typedef struct packed {
    logic                  cyc;
    logic                  we;
    logic [RAXM_SEL_W-1:0] sel;
    logic [RAXM_ADR_W-1:0] adr;
    logic [RAXM_DAT_W-1:0] dat;
  } raxm_wb_req_t;

  // Bus request driven while resident in a given state; all-zero outside bus states.
  function automatic raxm_wb_req_t raxm_bus_req(
    input raxm_init_state_t      st,
    input logic [RAXM_ADR_W-1:0] base,
    input logic [RAXM_OP_W-1:0]  op_a,
    input logic [RAXM_OP_W-1:0]  op_b
  );
    raxm_wb_req_t r;
    r = '0;
    unique case (st)
      ST_WR_A: begin
        r.cyc = 1'b1;
        r.we  = 1'b1;
        r.sel = 4'hF;
        r.adr = base + RAXM_OFS_OPA;
        r.dat = 32'(op_a);
      end
      ST_WR_B: begin
        r.cyc = 1'b1;
        r.we  = 1'b1;
        r.sel = 4'hF;
        r.adr = base + RAXM_OFS_OPB;
        r.dat = 32'(op_b);
      end
      ST_RD_RES: begin
        r.cyc = 1'b1;
        r.sel = 4'hF;
        r.adr = base + RAXM_OFS_RES;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_raxm_initiator_if.sv
// Wishbone classic bus bundle between the RAxM initiator and its responder.
interface wb_raxm_initiator_if;
  import raxm_pkg::*;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [RAXM_SEL_W-1:0] sel;
  logic [RAXM_ADR_W-1:0] adr;
  logic [RAXM_DAT_W-1:0] dat_w;
  logic [RAXM_DAT_W-1:0] dat_r;
  logic                  ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_raxm_timeout.sv
// Per-transfer wait counter; expired_o flags the cycle in which the count sits at LIMIT-1.
module wb_raxm_timeout
  import raxm_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [RAXM_TMO_W-1:0] cnt_q, cnt_d;
  logic                  expired_q, expired_d;

  // Counting stops at the limit; the owner clears on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_q) begin
      cnt_d = cnt_q + 8'd1;
    end
    expired_d = (cnt_d == RAXM_TMO_W'(LIMIT - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/wb_raxm_initiator.sv
// Wishbone classic initiator: writes operand A, operand B, reads the product from wb_RAxM
// for each accepted command, returning product or timeout error on the response port.
module wb_raxm_initiator
  import raxm_pkg::*;
#(
  parameter logic [RAXM_ADR_W-1:0] BASE_ADR       = 32'h3000_0000,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [RAXM_OP_W-1:0]  cmd_op_a_i,
  input  logic [RAXM_OP_W-1:0]  cmd_op_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [RAXM_DAT_W-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  wb_raxm_initiator_if.master   wbm
);

  raxm_init_state_t      state_q, state_d;
  logic [RAXM_OP_W-1:0]  op_a_q, op_a_d;
  logic [RAXM_OP_W-1:0]  op_b_q, op_b_d;
  raxm_wb_req_t          req_q, req_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [RAXM_DAT_W-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  tmo_clr_c, tmo_en_c, tmo_expired;

  wb_raxm_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .clr_i     (tmo_clr_c),
    .en_i      (tmo_en_c),
    .expired_o (tmo_expired)
  );

  // Next-state and registered-output decode; ack takes priority over a coincident timeout.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          op_a_d  = cmd_op_a_i;
          op_b_d  = cmd_op_b_i;
          state_d = ST_WR_A;
        end
      end
      ST_WR_A: begin
        if (wbm.ack) begin
          state_d = ST_WR_B;
        end else if (tmo_expired) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end
      end
      ST_WR_B: begin
        if (wbm.ack) begin
          state_d = ST_RD_RES;
        end else if (tmo_expired) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end
      end
      ST_RD_RES: begin
        if (wbm.ack) begin
          rsp_data_d = wbm.dat_r;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (tmo_expired) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_d       = raxm_bus_req(state_d, BASE_ADR, op_a_d, op_b_d);
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    tmo_clr_c   = (state_d != state_q);
    tmo_en_c    = req_q.cyc && !wbm.ack;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      req_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      req_q       <= req_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign wbm.cyc   = req_q.cyc;
  assign wbm.stb   = req_q.cyc;
  assign wbm.we    = req_q.we;
  assign wbm.sel   = req_q.sel;
  assign wbm.adr   = req_q.adr;
  assign wbm.dat_w = req_q.dat;

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
